seg7_scroller: RTL and testbench

- Parametrised multiplexed 7-segment scrolling driver for the fx2 board display bank.
- Holds a writable message buffer of hex/blank characters and scans NUM_DIGITS active-low digit selects at a refresh rate.
- Scrolls the visible window left, right, or bounce, or holds it static, at a slower scroll rate.
- Replaces the fixed-pattern, fixed-length scroller and sits directly between user logic and the board's select/segment pins.

---
 rtl/seg7_pkg.sv | 11 +
 rtl/hex_to_seg7.sv | 30 +++
 rtl/seg7_scroller.sv | 114 +++++++++++
 tb/tb_seg7_scroller.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared encodings for the 7-segment display blocks
package seg7_pkg;
    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_LEFT   = 2'b01;
    localparam logic [1:0] MODE_RIGHT  = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;
    localparam int         BLANK_BIT   = 4;
    localparam logic [4:0] CHAR_BLANK  = 5'b1_0000;
    localparam logic [7:0] SEG_BLANK   = 8'hFF;
    typedef enum logic {ST_LEFT, ST_RIGHT} dir_e;
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: {blank, hex} character to active-low {a,b,c,d,e,f,g,dp} pattern
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [4:0] ch,
    output logic [7:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        if (!ch[BLANK_BIT])
            case (ch[3:0])
                4'h0: seg = 8'b0000_0011;
                4'h1: seg = 8'b1001_1111;
                4'h2: seg = 8'b0010_0101;
                4'h3: seg = 8'b0000_1101;
                4'h4: seg = 8'b1001_1001;
                4'h5: seg = 8'b0100_1001;
                4'h6: seg = 8'b0100_0001;
                4'h7: seg = 8'b0001_1111;
                4'h8: seg = 8'b0000_0001;
                4'h9: seg = 8'b0000_1001;
                4'hA: seg = 8'b0001_0001;
                4'hB: seg = 8'b1100_0001;
                4'hC: seg = 8'b0110_0011;
                4'hD: seg = 8'b1000_0101;
                4'hE: seg = 8'b0110_0001;
                4'hF: seg = 8'b0111_0001;
            endcase
    end
endmodule

// File: rtl/seg7_scroller.sv
// seg7_scroller: multiplexed 7-segment driver scrolling a writable message buffer
module seg7_scroller
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int MSG_LEN     = 16,
    parameter int REFRESH_DIV = 4096,
    parameter int SCROLL_DIV  = 8388608
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [4:0]                 wr_data,
    input  logic [1:0]                 mode,
    input  logic                       restart,
    output logic [NUM_DIGITS-1:0]      select,
    output logic [7:0]                 display,
    output logic                       wrap
);
    localparam int AW = $clog2(MSG_LEN);
    localparam int PW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(SCROLL_DIV);
    localparam int XW = AW + 1;
    localparam logic [AW-1:0] LAST   = AW'(MSG_LEN - 1);
    localparam logic [AW-1:0] MAXOFF = AW'(MSG_LEN - NUM_DIGITS);
    localparam logic [XW-1:0] MLEN   = XW'(MSG_LEN);
    localparam logic [PW-1:0] PLAST  = PW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

    logic [RW-1:0] rcnt;
    logic [SW-1:0] scnt;
    logic [PW-1:0] p;
    logic [AW-1:0] offset, offset_n, idx;
    logic [XW-1:0] sum, diff;
    logic          refresh_tick, scroll_tick, wrap_n;
    logic [4:0]    msg [MSG_LEN];
    logic [7:0]    seg;
    dir_e          state, state_n;

    assign refresh_tick = rcnt == RW'(REFRESH_DIV - 1);
    assign scroll_tick  = scnt == SW'(SCROLL_DIV - 1);
    // offset+p < 2*MSG_LEN, so a single conditional subtract replaces the mod
    assign sum  = {1'b0, offset} + XW'(p);
    assign diff = sum - MLEN;
    assign idx  = sum >= MLEN ? diff[AW-1:0] : sum[AW-1:0];

    hex_to_seg7 u_dec (.ch(msg[idx]), .seg(seg));

    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < MSG_LEN; i++) msg[i] <= CHAR_BLANK;
        else if (wr_en)
            msg[wr_addr] <= wr_data;

    always_comb begin
        offset_n = offset;
        state_n  = state;
        wrap_n   = 1'b0;
        if (restart) begin
            offset_n = '0;
            state_n  = ST_LEFT;
        end else if (scroll_tick)
            case (mode)
                MODE_LEFT: begin
                    wrap_n   = offset == LAST;
                    offset_n = wrap_n ? '0 : offset + 1'b1;
                    state_n  = ST_LEFT;
                end
                MODE_RIGHT: begin
                    wrap_n   = offset == '0;
                    offset_n = wrap_n ? LAST : offset - 1'b1;
                    state_n  = ST_LEFT;
                end
                MODE_BOUNCE:
                    if (MSG_LEN > NUM_DIGITS) begin
                        if (state == ST_LEFT) begin
                            wrap_n   = offset >= MAXOFF;
                            state_n  = wrap_n ? ST_RIGHT : ST_LEFT;
                            offset_n = wrap_n ? offset : offset + 1'b1;
                        end else begin
                            wrap_n   = offset == '0;
                            state_n  = wrap_n ? ST_LEFT : ST_RIGHT;
                            offset_n = wrap_n ? offset : offset - 1'b1;
                        end
                    end
                default: state_n = ST_LEFT;
            endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rcnt    <= '0;
            scnt    <= '0;
            p       <= '0;
            select  <= '1;
            display <= SEG_BLANK;
            wrap    <= 1'b0;
            offset  <= '0;
            state   <= ST_LEFT;
        end else begin
            rcnt   <= refresh_tick ? '0 : rcnt + 1'b1;
            scnt   <= scroll_tick ? '0 : scnt + 1'b1;
            offset <= offset_n;
            state  <= state_n;
            wrap   <= wrap_n;
            if (refresh_tick) begin
                p       <= p == PLAST ? '0 : p + 1'b1;
                select  <= ~(ONE << (PLAST - p));
                display <= seg;
            end
        end
endmodule

// File: tb/tb_seg7_scroller.sv
// tb_seg7_scroller: directed vectors for the scrolling 7-segment driver
module tb_seg7_scroller;
    localparam logic [7:0] S0 = 8'b0000_0011, S1 = 8'b1001_1111, S5 = 8'b0100_1001;
    localparam logic [7:0] S7 = 8'b0001_1111, SE = 8'b0110_0001, SB = 8'hFF;
    localparam logic [1:0] MS = 2'b00, ML = 2'b01, MR = 2'b10, MB = 2'b11;

    typedef struct {
        logic [1:0] mode;
        logic       rs;
        logic [7:0] seg;
        logic       w;
    } vec_t;

    logic       clk = 0, rst = 0, wr_en = 0, restart = 0;
    logic [2:0] wr_addr = 0;
    logic [4:0] wr_data = 0;
    logic [1:0] mode = MS;
    logic [3:0] select;
    logic [7:0] display;
    logic       wrap;
    int         total = 0, bad = 0, cyc;
    vec_t       v [26];
    logic [4:0] text [8];
    logic [7:0] scan_seg [4];
    logic [3:0] sel_seq [4];

    seg7_scroller #(.NUM_DIGITS(4), .MSG_LEN(8), .REFRESH_DIV(4), .SCROLL_DIV(64)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mode(mode), .restart(restart), .select(select), .display(display), .wrap(wrap)
    );

    always #5 clk = ~clk;
    always @(posedge clk or posedge rst) if (rst) cyc <= 0; else cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic at(input int n);
        for (int g = 0; g < 10000 && cyc < n; g++) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        text = '{5'h01, 5'h07, 5'h00, 5'h01, 5'h00, 5'h0E, 5'h01, 5'h05};
        scan_seg = '{S1, S7, S0, S1};
        sel_seq = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        v[0]  = '{MS, 0, S1, 0};
        v[1]  = '{ML, 0, S7, 0};
        v[2]  = '{ML, 0, S0, 0};
        v[3]  = '{ML, 0, S1, 0};
        v[4]  = '{ML, 0, S0, 0};
        v[5]  = '{ML, 0, SE, 0};
        v[6]  = '{ML, 0, S1, 0};
        v[7]  = '{ML, 0, S5, 0};
        v[8]  = '{ML, 0, S1, 1};
        v[9]  = '{MR, 0, S5, 1};
        v[10] = '{MB, 1, S1, 0};
        v[11] = '{MB, 0, S7, 0};
        v[12] = '{MB, 0, S0, 0};
        v[13] = '{MB, 0, S1, 0};
        v[14] = '{MB, 0, S0, 0};
        v[15] = '{MB, 0, S0, 1};
        v[16] = '{MB, 0, S1, 0};
        v[17] = '{MB, 0, S0, 0};
        v[18] = '{MB, 0, S7, 0};
        v[19] = '{MB, 0, S1, 0};
        v[20] = '{MB, 0, S1, 1};
        v[21] = '{MB, 0, S7, 0};
        v[22] = '{MB, 1, S1, 0};
        v[23] = '{MR, 0, S5, 1};
        v[24] = '{MB, 0, S5, 1};
        v[25] = '{MB, 0, S1, 0};

        #2 rst = 1;
        #1;
        chk("rst_select", 32'(select), 32'hF);
        chk("rst_display", 32'(display), 32'(SB));
        chk("rst_wrap", 32'(wrap), 0);
        @(negedge clk);
        @(negedge clk) rst = 0;
        for (int i = 1; i < 4; i++) begin
            at(i);
            chk("pre_tick_select", 32'(select), 32'hF);
            chk("pre_tick_display", 32'(display), 32'(SB));
        end
        for (int i = 0; i < 4; i++) begin
            at(4 + 4 * i);
            chk("blank_scan_select", 32'(select), 32'(sel_seq[i]));
            chk("blank_scan_display", 32'(display), 32'(SB));
        end
        at(17);
        for (int i = 0; i < 8; i++) begin
            wr_en = 1; wr_addr = 3'(i); wr_data = text[i];
            @(negedge clk);
        end
        wr_en = 0;
        for (int i = 0; i < 4; i++) begin
            at(36 + 4 * i);
            chk("static_select", 32'(select), 32'(sel_seq[i]));
            chk("static_digit", 32'(display), 32'(scan_seg[i]));
        end

        for (int k = 1; k <= 26; k++) begin
            at(64 * k - 1);
            mode = v[k-1].mode;
            restart = v[k-1].rs;
            at(64 * k);
            restart = 0;
            chk($sformatf("wrap_tick%0d", k), 32'(wrap), 32'(v[k-1].w));
            at(64 * k + 1);
            chk($sformatf("wrap_drop%0d", k), 32'(wrap), 0);
            at(64 * k + 4);
            chk($sformatf("left_sel%0d", k), 32'(select), 32'h7);
            chk($sformatf("left_digit%0d", k), 32'(display), 32'(v[k-1].seg));
        end

        at(64 * 26 + 30);
        mode = ML;
        at(64 * 28);
        chk("wrap_before_rst", 32'(wrap), 1);
        #1 rst = 1;
        #1;
        chk("midrun_rst_select", 32'(select), 32'hF);
        chk("midrun_rst_display", 32'(display), 32'(SB));
        chk("midrun_rst_wrap", 32'(wrap), 0);
        repeat (2) @(negedge clk);
        mode = MS;
        rst = 0;
        at(3);
        chk("post_rst_select", 32'(select), 32'hF);
        chk("post_rst_display", 32'(display), 32'(SB));
        at(4);
        chk("post_rst_blank0", 32'(display), 32'(SB));
        at(5);
        wr_en = 1; wr_addr = 3'd0; wr_data = 5'h05;
        @(negedge clk);
        wr_addr = 3'd1; wr_data = 5'h0E;
        @(negedge clk);
        wr_en = 0;
        chk("write_not_yet_shown", 32'(display), 32'(SB));
        at(8);
        chk("write_next_step_sel", 32'(select), 32'hB);
        chk("write_next_step", 32'(display), 32'(SE));
        at(12);
        chk("post_rst_blank2", 32'(display), 32'(SB));
        at(20);
        chk("write_addr0_sel", 32'(select), 32'h7);
        chk("write_addr0", 32'(display), 32'(S5));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
